// File: rtl/shift_left_pipe.sv
// Registered lane shifter with valid/ready flow control and a 2-entry output queue.
// Define SLP_ERR_COUNT_EN to add the saturating err_cnt port counting dropped illegal beats.
module shift_left_pipe #(
  parameter int LANE_W    = 12,
  parameter int LANES     = 8,
  parameter int SHIFT_W   = 3,
  parameter int MAX_SHIFT = 5,
  parameter int ERR_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in_data,
  input  logic [SHIFT_W-1:0]        in_shift,
  input  logic [LANE_W-1:0]         in_fill,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic                      err_pulse
`ifdef SLP_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0]      err_cnt
`endif
);

  localparam int DATA_W = LANES * LANE_W;

  logic [1:0]        count_reg;
  logic [DATA_W-1:0] head_reg;
  logic [DATA_W-1:0] tail_reg;
  logic              busy_reg;
  logic              err_pulse_reg;

  logic              shift_legal;
  logic              accept;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] shifted_raw;
  logic [DATA_W-1:0] shifted_word;

  assign shift_legal = int'(in_shift) <= MAX_SHIFT;
  assign shifted_raw = in_data << (int'(in_shift) * LANE_W);

  // Lanes below the shift amount take the fill value instead of the zeros shifted in.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign shifted_word[gi*LANE_W +: LANE_W] =
        (int'(in_shift) > gi) ? in_fill : shifted_raw[gi*LANE_W +: LANE_W];
    end
  endgenerate

  // busy_reg holds in_ready low throughout reset without looking at rst combinationally.
  assign in_ready  = !busy_reg && (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = head_reg;
  assign err_pulse = err_pulse_reg;

  assign accept = in_valid && in_ready;
  assign push   = accept && shift_legal;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= 2'd0;
      head_reg      <= '0;
      tail_reg      <= '0;
      busy_reg      <= 1'b1;
      err_pulse_reg <= 1'b0;
    end else begin
      busy_reg      <= 1'b0;
      err_pulse_reg <= accept && !shift_legal;
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= shifted_word;
          else                   tail_reg <= shifted_word;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          if (count_reg == 2'd2) head_reg <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        // Push with pop only happens at count 1: the new beat replaces the head.
        2'b11: head_reg <= shifted_word;
        default: ;
      endcase
    end
  end

`ifdef SLP_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (err_pulse_reg && (err_cnt_reg != {ERR_CNT_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_shift_left_pipe.sv
// Self-checking bench for shift_left_pipe: vector table, hand-written queue/reset
// sequences and randomized streaming against a lane-level queue model.
module tb_shift_left_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [2:0]  in_shift;
  logic [11:0] in_fill;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic        err_pulse;
`ifdef SLP_ERR_COUNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [95:0] mq[$];
  logic        err_exp   = 1'b0;
  int          err_model = 0;

  always #5 clk = ~clk;

  shift_left_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_fill   (in_fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_pulse (err_pulse)
`ifdef SLP_ERR_COUNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic [95:0] data;
    logic [2:0]  shift;
    logic [11:0] fill;
    logic [95:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // out lane k = in lane (k-s) for k >= s, otherwise the fill lane
  function automatic logic [95:0] ref_shift(input logic [95:0] d, input int s, input logic [11:0] f);
    logic [95:0] r;
    for (int k = 0; k < 8; k++) begin
      if (k >= s) r[k*12 +: 12] = d[(k-s)*12 +: 12];
      else        r[k*12 +: 12] = f;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs();
    chk("out_valid", {95'd0, out_valid}, {95'd0, (mq.size() != 0)});
    if (mq.size() != 0) chk("out_data", out_data, mq[0]);
    chk("in_ready", {95'd0, in_ready}, {95'd0, (mq.size() < 2)});
    chk("err_pulse", {95'd0, err_pulse}, {95'd0, err_exp});
`ifdef SLP_ERR_COUNT_EN
    chk("err_cnt", {88'd0, err_cnt}, 96'(err_model));
`endif
  endtask

  // One clock of stimulus; the model predicts handshakes from its own occupancy.
  task automatic drive_cycle(input logic v, input logic [95:0] d, input logic [2:0] s,
                             input logic [11:0] f, input logic ordy, output logic acc);
    logic pop_e;
    logic legal;
    in_valid  = v;
    in_data   = d;
    in_shift  = s;
    in_fill   = f;
    out_ready = ordy;
    acc   = v && (mq.size() < 2);
    pop_e = ordy && (mq.size() != 0);
    legal = (s <= 3'd5);
    tick();
    if (pop_e) begin
      $display("pop  data=%h", mq[0]);
      void'(mq.pop_front());
    end
    if (acc && legal) begin
      mq.push_back(ref_shift(d, int'(s), f));
      $display("push data=%h shift=%0d fill=%h", d, s, f);
    end
    if (err_exp && err_model < 255) err_model++;
    err_exp = acc && !legal;
    if (acc && !legal) $display("drop shift=%0d", s);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    drive_cycle(1'b0, 96'd0, 3'd0, 12'd0, ordy, acc);
  endtask

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[7];
    logic        acc;
    logic [95:0] d_seq;
    logic [95:0] d_mix;
    logic [95:0] b1;
    logic [95:0] b3;
    logic [2:0]  s3;
    logic [11:0] f3;
    int          sent;
    int          cyc;
    logic        tog;

    d_seq = {12'h707, 12'h606, 12'h505, 12'h404, 12'h303, 12'h202, 12'h101, 12'h000};
    d_mix = {12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h012, 12'h345, 12'h678};
    vecs[0] = '{d_seq, 3'd2, 12'hABC,
                {12'h505, 12'h404, 12'h303, 12'h202, 12'h101, 12'h000, 12'hABC, 12'hABC}, 1'b0};
    vecs[1] = '{d_seq, 3'd0, 12'hFFF, d_seq, 1'b0};
    vecs[2] = '{d_seq, 3'd5, 12'hFFF,
                {12'h202, 12'h101, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 1'b0};
    vecs[3] = '{d_seq, 3'd6, 12'h111, 96'd0, 1'b1};
    vecs[4] = '{d_seq, 3'd7, 12'h222, 96'd0, 1'b1};
    vecs[5] = '{d_seq, 3'd1, 12'h000,
                {12'h606, 12'h505, 12'h404, 12'h303, 12'h202, 12'h101, 12'h000, 12'h000}, 1'b0};
    vecs[6] = '{d_mix, 3'd3, 12'h5A5,
                {12'hABC, 12'hDEF, 12'h012, 12'h345, 12'h678, 12'h5A5, 12'h5A5, 12'h5A5}, 1'b0};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_fill = '0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("rst_out_data", out_data, 96'd0);
    chk("rst_err_pulse", {95'd0, err_pulse}, 96'd0);
    chk("rst_in_ready", {95'd0, in_ready}, 96'd0);
`ifdef SLP_ERR_COUNT_EN
    chk("rst_err_cnt", {88'd0, err_cnt}, 96'd0);
`endif
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {95'd0, in_ready}, 96'd1);

    // Vector table: each beat alone into an empty queue with out_ready=1
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b1, vecs[i].data, vecs[i].shift, vecs[i].fill, 1'b1, acc);
      chk($sformatf("tbl%0d_valid", i), {95'd0, out_valid}, {95'd0, !vecs[i].exp_err});
      chk($sformatf("tbl%0d_err", i), {95'd0, err_pulse}, {95'd0, vecs[i].exp_err});
      chk($sformatf("tbl%0d_ready", i), {95'd0, in_ready}, 96'd1);
      if (!vecs[i].exp_err) chk($sformatf("tbl%0d_data", i), out_data, vecs[i].exp_data);
      idle(1'b1);
      chk($sformatf("tbl%0d_drained", i), {95'd0, out_valid}, 96'd0);
    end
    idle(1'b1);
`ifdef SLP_ERR_COUNT_EN
    chk("two_errors_counted", {88'd0, err_cnt}, 96'd2);
`endif

    // Backpressure: two beats fill the queue, head held, third waits for space
    b1 = rand96();
    drive_cycle(1'b1, b1, 3'd4, 12'h0F0, 1'b0, acc);
    drive_cycle(1'b1, rand96(), 3'd1, 12'h00F, 1'b0, acc);
    chk("full_in_ready", {95'd0, in_ready}, 96'd0);
    idle(1'b0);
    chk("hold_head", out_data, ref_shift(b1, 4, 12'h0F0));
    b3 = rand96(); s3 = 3'd2; f3 = 12'hC3C;
    acc = 1'b0;
    for (cyc = 0; cyc < 10 && !acc; cyc++) drive_cycle(1'b1, b3, s3, f3, 1'b1, acc);
    chk("beat3_accepted", {95'd0, acc}, 96'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("bp_drained", {95'd0, out_valid}, 96'd0);

    // Random streaming with out_ready toggling each cycle
    sent = 0; tog = 1'b1;
    for (cyc = 0; cyc < 300 && sent < 20; cyc++) begin
      drive_cycle(($urandom_range(0, 3) != 0), rand96(), 3'($urandom_range(0, 7)),
                  12'($urandom), tog, acc);
      if (acc) sent++;
      tog = !tog;
    end
    chk("stream_sent", 96'(sent), 96'd20);
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("stream_drained", {95'd0, out_valid}, 96'd0);

    // Reset with a full queue flushes both entries; a beat presented during reset is lost
    drive_cycle(1'b1, rand96(), 3'd6, 12'h0, 1'b0, acc);
    drive_cycle(1'b1, rand96(), 3'd0, 12'h0, 1'b0, acc);
    drive_cycle(1'b1, rand96(), 3'd3, 12'h0, 1'b0, acc);
    chk("pre_rst_full", {95'd0, in_ready}, 96'd0);
    rst = 1'b1; in_valid = 1'b1; in_data = rand96(); in_shift = 3'd1;
    tick();
    mq.delete(); err_exp = 1'b0; err_model = 0;
    chk("mid_rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("mid_rst_in_ready", {95'd0, in_ready}, 96'd0);
    chk("mid_rst_err_pulse", {95'd0, err_pulse}, 96'd0);
`ifdef SLP_ERR_COUNT_EN
    chk("mid_rst_err_cnt", {88'd0, err_cnt}, 96'd0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("after_rst_in_ready", {95'd0, in_ready}, 96'd1);
    chk("after_rst_out_valid", {95'd0, out_valid}, 96'd0);
    drive_cycle(1'b1, rand96(), 3'd5, 12'h777, 1'b1, acc);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
